// File: rtl/cpuy_pkg.sv
// Shared types and constants for the cpuy 8-bit core.
package cpuy_pkg;

    // Default program-memory address width (and PC width).
    localparam int CPUY_ADDR_W = 8;

    // Opcode bit that marks a two-byte instruction (opcode followed by an operand byte).
    localparam int OPC_OPERAND_BIT = 7;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        FETCH_OP  = 2'd1,
        FETCH_ARG = 2'd2,
        ISSUE     = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/cpuy_fetch.sv
// Instruction fetch sequencer for the cpuy core: owns the PC, reads opcode and
// optional operand bytes over a req/ack handshake and hands complete
// instructions to the ucode decoder over valid/ready. Jump redirects are taken
// only when an instruction is transferred.
module cpuy_fetch
    import cpuy_pkg::*;
#(
    parameter int                ADDR_W   = CPUY_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    // program memory read port
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    // instruction out to the ucode decoder
    output logic [7:0]        opcode,
    output logic [7:0]        operand,
    output logic              instr_valid,
    input  logic              instr_ready,
    // redirect from execute
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] PC_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [7:0]        operand_q, operand_d;
    logic              instr_valid_q, instr_valid_d;

    // Next-state, PC and instruction-register update for the fetch FSM.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;

        unique case (state_q)
            BOOT: begin
                state_d = FETCH_OP;
            end
            FETCH_OP: begin
                if (mem_ack) begin
                    opcode_d  = mem_rdata;
                    operand_d = 8'h00;
                    pc_d      = pc_q + PC_INC;
                    state_d   = mem_rdata[OPC_OPERAND_BIT] ? FETCH_ARG : ISSUE;
                end
            end
            FETCH_ARG: begin
                if (mem_ack) begin
                    operand_d = mem_rdata;
                    pc_d      = pc_q + PC_INC;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    if (jump_en) begin
                        pc_d = jump_target;
                    end
                    state_d = FETCH_OP;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        instr_valid_d = (state_d == ISSUE);
    end

    // State, PC and instruction registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            opcode_q      <= 8'h00;
            operand_q     <= 8'h00;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            opcode_q      <= opcode_d;
            operand_q     <= operand_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Memory request is decoded from state and PC only; no input reaches it combinationally.
    always_comb begin
        mem_rd   = (state_q == FETCH_OP) || (state_q == FETCH_ARG);
        mem_addr = pc_q;
    end

    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_cpuy_fetch.sv
// Self-checking bench for cpuy_fetch: directed handshake/latency cases, a
// randomized run against a byte-level program model with a scoreboard, and a
// reset in the middle of an operand fetch.
module tb_cpuy_fetch;

    typedef struct {
        logic [7:0] op;
        logic [7:0] opd;
        logic [7:0] pc_after;
        logic [7:0] a0;
        logic [7:0] a1;
        bit         two;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic [7:0] opcode;
    logic [7:0] operand;
    logic       instr_valid;
    logic       instr_ready;
    logic       jump_en;
    logic [7:0] jump_target;
    logic [7:0] pc;

    cpuy_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .opcode      (opcode),
        .operand     (operand),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] mem [0:255];
    exp_t       exp_q[$];
    logic [7:0] acked_q[$];
    bit         jmp_a [0:511];
    logic [7:0] tgt_a [0:511];

    // control from the main sequence
    bit         drv_en = 0;
    bit         mon_en = 0;
    bit         resp_en = 1;
    int         force_wait = 0;
    logic       man_ready = 0;
    logic       man_jump = 0;
    logic [7:0] man_target = 8'h00;
    logic       man_ack = 0;
    logic [7:0] man_rdata = 8'h00;

    // driven by the responder / driver processes
    logic       rsp_ack = 0;
    logic [7:0] rsp_rdata = 8'h00;
    logic       rnd_ready = 0;
    logic       rnd_jump = 0;
    logic [7:0] rnd_target = 8'h00;

    assign mem_ack     = resp_en ? rsp_ack   : man_ack;
    assign mem_rdata   = resp_en ? rsp_rdata : man_rdata;
    assign instr_ready = drv_en  ? rnd_ready : man_ready;
    assign jump_en     = drv_en  ? rnd_jump  : man_jump;
    assign jump_target = drv_en  ? rnd_target : man_target;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Program model: walk memory byte by byte from start, decide a redirect per instruction.
    task automatic build_expected(input logic [7:0] start, input int n);
        logic [7:0] p;
        exp_t e;
        p = start;
        for (int i = 0; i < n; i++) begin
            e.a0  = p;
            e.op  = mem[p];
            p     = p + 8'd1;
            e.two = e.op[7];
            e.a1  = p;
            e.opd = 8'h00;
            if (e.two) begin
                e.opd = mem[p];
                p     = p + 8'd1;
            end
            e.pc_after = p;
            exp_q.push_back(e);
            jmp_a[i] = ($urandom_range(0, 2) == 0);
            tgt_a[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            if (jmp_a[i]) p = tgt_a[i];
        end
    endtask

    // Memory responder: random or forced wait states, junk acks while idle.
    int   wait_left = 0;
    bit   busy = 0;
    always @(negedge clk) begin
        if (rst) acked_q.delete();
        if (mem_rd) begin
            if (!busy) begin
                busy      = 1;
                wait_left = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
            end
            if (wait_left == 0) begin
                rsp_ack   = 1'b1;
                rsp_rdata = mem[mem_addr];
                acked_q.push_back(mem_addr);
                busy      = 0;
            end else begin
                rsp_ack   = 1'b0;
                rsp_rdata = 8'($urandom);
                wait_left--;
            end
        end else begin
            busy      = 0;
            rsp_ack   = 1'($urandom_range(0, 1));
            rsp_rdata = 8'($urandom);
        end
    end

    // Consumer driver: random backpressure, scheduled jumps on transfers, stray jump pulses otherwise.
    int k = 0;
    always @(negedge clk) begin
        if (!drv_en) k = 0;
        rnd_ready = ($urandom_range(0, 3) != 0);
        if (instr_valid && rnd_ready) begin
            rnd_jump   = (k < 512) ? jmp_a[k] : 1'b0;
            rnd_target = (k < 512) ? tgt_a[k] : 8'h00;
            if (drv_en) k++;
        end else begin
            rnd_jump   = 1'($urandom_range(0, 1));
            rnd_target = 8'($urandom);
        end
    end

    // Monitor: pops the scoreboard when a new instruction is presented.
    bit         seen = 0;
    logic       prev_rd = 0;
    logic       prev_ack = 0;
    logic [7:0] prev_addr = 8'h00;
    logic [7:0] held_op = 8'h00;
    logic [7:0] held_opd = 8'h00;
    always @(negedge clk) begin
        exp_t e;
        logic [7:0] a;
        #2;
        if (mon_en) begin
            if (mem_rd) check("mem_addr_is_pc", 32'(mem_addr), 32'(pc));
            if (prev_rd && !prev_ack && mem_rd) check("addr_held_in_wait", 32'(mem_addr), 32'(prev_addr));
            if (instr_valid) begin
                check("no_rd_in_issue", 32'(mem_rd), 32'd0);
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_instr", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("opcode", 32'(opcode), 32'(e.op));
                        check("operand", 32'(operand), 32'(e.opd));
                        check("pc_after_fetch", 32'(pc), 32'(e.pc_after));
                        if (acked_q.size() < (e.two ? 2 : 1)) begin
                            check("fetch_count", 32'(acked_q.size()), e.two ? 32'd2 : 32'd1);
                            acked_q.delete();
                        end else begin
                            a = acked_q.pop_front();
                            check("opcode_addr", 32'(a), 32'(e.a0));
                            if (e.two) begin
                                a = acked_q.pop_front();
                                check("operand_addr", 32'(a), 32'(e.a1));
                            end
                        end
                    end
                    held_op  = opcode;
                    held_opd = operand;
                    seen     = 1;
                end else begin
                    check("opcode_stable", 32'(opcode), 32'(held_op));
                    check("operand_stable", 32'(operand), 32'(held_opd));
                end
            end else begin
                seen = 0;
            end
        end
        prev_rd   = mem_rd;
        prev_ack  = mem_ack;
        prev_addr = mem_addr;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        rst = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h02;
        mem[8'h40] = 8'h85;
        mem[8'h41] = 8'h3C;
        mem[8'h42] = 8'h07;

        // Reset state
        repeat (2) step();
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_pc", 32'(pc), 32'h00);
        check("rst_opcode", 32'(opcode), 32'h00);
        check("rst_operand", 32'(operand), 32'h00);

        // One-byte instruction with ack in the request cycle
        rst = 1'b0;
        step();
        check("t1_mem_rd", 32'(mem_rd), 32'd1);
        check("t1_addr", 32'(mem_addr), 32'h00);
        check("t1_valid_early", 32'(instr_valid), 32'd0);
        step();
        check("t1_valid", 32'(instr_valid), 32'd1);
        check("t1_opcode", 32'(opcode), 32'h02);
        check("t1_operand", 32'(operand), 32'h00);
        check("t1_pc", 32'(pc), 32'h01);

        // Backpressure with a stray jump pulse: nothing moves
        man_jump   = 1'b1;
        man_target = 8'h55;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_opcode", 32'(opcode), 32'h02);
            check("stall_mem_rd", 32'(mem_rd), 32'd0);
            check("stall_pc", 32'(pc), 32'h01);
        end

        // Transfer with a jump to 0x40, then a two-byte instruction
        man_ready  = 1'b1;
        man_target = 8'h40;
        step();
        check("jump_mem_rd", 32'(mem_rd), 32'd1);
        check("jump_addr", 32'(mem_addr), 32'h40);
        man_ready  = 1'b0;
        man_target = 8'h55;
        step();
        check("arg_addr", 32'(mem_addr), 32'h41);
        check("arg_mem_rd", 32'(mem_rd), 32'd1);
        step();
        check("t2_valid", 32'(instr_valid), 32'd1);
        check("t2_opcode", 32'(opcode), 32'h85);
        check("t2_operand", 32'(operand), 32'h3C);
        check("t2_pc", 32'(pc), 32'h42);

        // Three wait states on the next opcode read
        man_jump   = 1'b0;
        man_ready  = 1'b1;
        force_wait = 3;
        step();
        man_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            check("wait_mem_rd", 32'(mem_rd), 32'd1);
            check("wait_addr", 32'(mem_addr), 32'h42);
            check("wait_valid", 32'(instr_valid), 32'd0);
        end
        step();
        check("t3_valid", 32'(instr_valid), 32'd1);
        check("t3_opcode", 32'(opcode), 32'h07);
        check("t3_pc", 32'(pc), 32'h43);

        // Randomized run against the program model
        rst = 1'b1;
        repeat (2) step();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'hFF] = 8'h81;
        mem[8'h00] = 8'h11;
        build_expected(8'h00, 300);
        force_wait = -1;
        drv_en     = 1;
        mon_en     = 1;
        rst        = 1'b0;
        cycles     = 0;
        while (exp_q.size() > 0 && cycles < 20000) begin
            step();
            cycles++;
        end
        check("random_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 0;
        drv_en = 0;

        // Reset while waiting on an operand read; acks in reset and BOOT are ignored
        man_ready  = 1'b0;
        man_jump   = 1'b0;
        force_wait = 0;
        rst        = 1'b1;
        mem[8'h00] = 8'h81;
        mem[8'h01] = 8'h5A;
        repeat (2) step();
        rst = 1'b0;
        step();
        check("r_fetch_addr", 32'(mem_addr), 32'h00);
        force_wait = 100;
        step();
        check("r_arg_mem_rd", 32'(mem_rd), 32'd1);
        check("r_arg_addr", 32'(mem_addr), 32'h01);
        check("r_arg_opcode", 32'(opcode), 32'h81);
        repeat (2) step();
        check("r_arg_wait_rd", 32'(mem_rd), 32'd1);
        check("r_arg_wait_valid", 32'(instr_valid), 32'd0);
        rst        = 1'b1;
        resp_en    = 0;
        man_ack    = 1'b1;
        man_rdata  = 8'hAA;
        force_wait = 0;
        step();
        check("r_mem_rd", 32'(mem_rd), 32'd0);
        check("r_pc", 32'(pc), 32'h00);
        check("r_valid", 32'(instr_valid), 32'd0);
        check("r_opcode", 32'(opcode), 32'h00);
        rst = 1'b0;
        step();
        resp_en = 1;
        man_ack = 1'b0;
        check("boot_ack_pc", 32'(pc), 32'h00);
        check("boot_ack_rd", 32'(mem_rd), 32'd1);
        check("boot_ack_addr", 32'(mem_addr), 32'h00);
        check("boot_ack_valid", 32'(instr_valid), 32'd0);
        repeat (2) step();
        check("r2_valid", 32'(instr_valid), 32'd1);
        check("r2_opcode", 32'(opcode), 32'h81);
        check("r2_operand", 32'(operand), 32'h5A);
        check("r2_pc", 32'(pc), 32'h02);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
